// File: rtl/cam_pkg.sv
// Shared definitions for the CAM request sequencer.
// Holds the op codes, the sequencer state enum and the default CAM sizing.
package cam_pkg;

  localparam int         DEF_NB_MEM    = 16;
  localparam int         DEF_SIZE_ADDR = 4;
  localparam logic [7:0] DEF_FILL      = 8'hFF;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_LOOK,
    ST_CAPT,
    ST_RESP
  } seq_state_t;

  // Write and invalidate share the single-cycle CAM write path.
  function automatic logic is_store_op(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_INVAL);
  endfunction

endpackage

// File: rtl/cam_seq.sv
// Request sequencer in front of a 16-entry CAM: init sweep, write/invalidate/lookup
// requests, and a per-entry valid bitmap that masks filler and stale hits.
module cam_seq
  import cam_pkg::*;
#(
  parameter int         NB_MEM    = DEF_NB_MEM,
  parameter int         SIZE_ADDR = DEF_SIZE_ADDR,
  parameter logic [7:0] FILL      = DEF_FILL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [SIZE_ADDR-1:0] req_addr,
  input  logic [7:0]           req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [SIZE_ADDR-1:0] rsp_idx,
  output logic                 init_done,
  output logic                 cam_enable,
  output logic                 cam_write,
  output logic [SIZE_ADDR:0]   cam_addr,
  output logic [7:0]           cam_data,
  input  logic [SIZE_ADDR:0]   cam_out,
  input  logic                 cam_found
);

  localparam logic [SIZE_ADDR-1:0] LAST_IDX = SIZE_ADDR'(NB_MEM - 1);

  seq_state_t           state;
  logic [SIZE_ADDR-1:0] init_cnt;
  logic [SIZE_ADDR-1:0] addr_q;
  logic [1:0]           op_q;
  logic [NB_MEM-1:0]    valid;

  logic [SIZE_ADDR-1:0] match_idx;
  logic                 match_hit;
  logic                 unused_cam_out_msb;

  // The CAM reports a raw match; only entries we have written count as hits.
  assign match_idx          = cam_out[SIZE_ADDR-1:0];
  assign match_hit          = cam_found & valid[match_idx];
  assign unused_cam_out_msb = cam_out[SIZE_ADDR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      addr_q     <= '0;
      op_q       <= OP_LOOKUP;
      valid      <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_idx    <= '0;
      init_done  <= 1'b0;
      cam_enable <= 1'b0;
      cam_write  <= 1'b0;
      cam_addr   <= '0;
      cam_data   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          cam_enable <= 1'b0;
          cam_write  <= 1'b1;
          cam_addr   <= {1'b0, init_cnt};
          cam_data   <= FILL;
          init_cnt   <= init_cnt + 1'b1;
          if (init_cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end

        // CAM strobes for the accepted op are registered here so they are
        // live for exactly the following WRITE or LOOK cycle.
        ST_IDLE: begin
          cam_enable <= 1'b0;
          cam_write  <= 1'b0;
          if (req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            if (req_op == OP_LOOKUP) begin
              state      <= ST_LOOK;
              req_ready  <= 1'b0;
              cam_enable <= 1'b1;
              cam_data   <= req_data;
            end else if (is_store_op(req_op)) begin
              state     <= ST_WRITE;
              req_ready <= 1'b0;
              cam_write <= 1'b1;
              cam_addr  <= {1'b0, req_addr};
              cam_data  <= (req_op == OP_INVAL) ? FILL : req_data;
            end
          end
        end

        ST_WRITE: begin
          cam_write     <= 1'b0;
          valid[addr_q] <= (op_q == OP_WRITE);
          state         <= ST_IDLE;
          req_ready     <= 1'b1;
        end

        // cam_data keeps the key through CAPT so the CAM's index output stays valid.
        ST_LOOK: begin
          cam_enable <= 1'b0;
          state      <= ST_CAPT;
        end

        ST_CAPT: begin
          rsp_hit   <= match_hit;
          rsp_idx   <= match_hit ? match_idx : '0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
